// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset vector and the per-instruction fetch queue entry.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_jump;
    logic [31:0] pred_target;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at address issue, filled when SRAM data
// returns (in request order) and popped by decode. Flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          alloc_pred_jump,
  input  logic [31:0]   alloc_pred_target,
  input  logic          fill,
  input  logic [31:0]   fill_inst,
  input  logic          pop,
  output logic          head_valid,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst,
  output logic          head_pred_jump,
  output logic [31:0]   head_pred_target,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr, fill_ptr;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) tail_ptr <= tail_ptr + PW'(1);
      if (fill)  fill_ptr <= fill_ptr + PW'(1);
      if (pop)   head_ptr <= head_ptr + PW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

  // NOTE: the entry array has no reset; count gates every read and alloc clears filled.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      if (alloc) begin
        mem[tail_ptr] <= '{pc: alloc_pc, inst: 32'h0, pred_jump: alloc_pred_jump,
                           pred_target: alloc_pred_target, filled: 1'b0};
      end
      if (fill) begin
        mem[fill_ptr].inst   <= fill_inst;
        mem[fill_ptr].filled <= 1'b1;
      end
    end
  end

  assign head_valid       = (count != '0) && mem[head_ptr].filled;
  assign head_pc          = mem[head_ptr].pc;
  assign head_inst        = mem[head_ptr].inst;
  assign head_pred_jump   = mem[head_ptr].pred_jump;
  assign head_pred_target = mem[head_ptr].pred_target;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch front end: owns the fetch PC, issues SRAM reads steered by the branch predictor,
// and hands instructions plus their predictions to decode in order.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        bp_predict_en,
  output logic [31:0] bp_old_PC,
  input  logic [31:0] bp_new_PC,
  input  logic        bp_predict_jump,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_pred_jump,
  output logic [31:0] if_pred_target
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEPTH + 1) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] count, unfilled;
  logic [DW-1:0] discard_cnt, discard_next;
  logic          head_valid, accept, drop_fill, keep_fill, pop;

  assign inst_req      = resetn && (count < CW'(DEPTH)) && !redirect_valid;
  assign bp_predict_en = inst_req;
  assign inst_addr     = pc;
  assign bp_old_PC     = pc;
  assign accept        = inst_req && inst_addr_ok;
  // Data for requests issued before a redirect is still in flight and must be swallowed.
  assign drop_fill     = inst_data_ok && (discard_cnt != '0);
  assign keep_fill     = inst_data_ok && (discard_cnt == '0);
  assign if_valid      = resetn && head_valid;
  assign pop           = if_valid && if_ready;

  // NOTE: default assignment comes first so no latch is inferred.
  always_comb begin
    discard_next = discard_cnt - DW'(drop_fill);
    if (redirect_valid) begin
      discard_next = discard_next + DW'(unfilled) + DW'(accept) - DW'(keep_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      discard_cnt <= '0;
    end else begin
      discard_cnt <= discard_next;
      if (redirect_valid) pc <= redirect_pc;
      else if (accept)    pc <= bp_new_PC;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (redirect_valid),
    .alloc             (accept),
    .alloc_pc          (pc),
    .alloc_pred_jump   (bp_predict_jump),
    .alloc_pred_target (bp_new_PC),
    .fill              (keep_fill && !redirect_valid),
    .fill_inst         (inst_rdata),
    .pop               (pop && !redirect_valid),
    .head_valid        (head_valid),
    .head_pc           (if_pc),
    .head_inst         (if_inst),
    .head_pred_jump    (if_pred_jump),
    .head_pred_target  (if_pred_target),
    .count             (count),
    .unfilled          (unfilled)
  );

  a_no_orphan_data: assert property (@(posedge clk) disable iff (!resetn)
    inst_data_ok |-> (unfilled != '0 || discard_cnt != '0));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table, hand-written corner sequences, and a
// randomized run against a transaction-level model of the fetch stream.
module tb_fetch_pc_gen;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bp_predict_en, bp_predict_jump;
  logic [31:0] bp_old_PC, bp_new_PC;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0;
  logic        if_valid, if_ready = 1'b0, if_pred_jump;
  logic [31:0] if_pc, if_inst, if_pred_target;

  int bp_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Predictor stand-in: mode 1 takes one fixed branch, mode 2 a pseudo-random set.
  function automatic logic [32:0] pred_fn(input logic [31:0] pc, input int mode);
    if (mode == 1 && pc == 32'hBFC0_0008) return {1'b1, 32'hBFC0_0100};
    if (mode == 2 && pc[4:2] == 3'b110)   return {1'b1, pc + 32'h124};
    return {1'b0, pc + 32'd4};
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign {bp_predict_jump, bp_new_PC} = pred_fn(bp_old_PC, bp_mode);

  fetch_pc_gen #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .bp_predict_en(bp_predict_en), .bp_old_PC(bp_old_PC),
    .bp_new_PC(bp_new_PC), .bp_predict_jump(bp_predict_jump),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pred_jump(if_pred_jump), .if_pred_target(if_pred_target)
  );

  // Reference model: instructions decode should see, and reads still owed by the SRAM.
  typedef struct { logic [31:0] pc; bit pj; logic [31:0] tgt; bit filled; } exp_t;
  typedef struct { logic [31:0] addr; bit live; } pend_t;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] model_pc = RST_PC;

  logic        s_req, s_valid, s_pj, s_acc, s_pop;
  logic [31:0] s_addr, s_pc, s_inst, s_tgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    check("rst_inst_req", inst_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_predict_en", bp_predict_en, 0);
    @(posedge clk);
    exp_q.delete();
    pend_q.delete();
    model_pc = RST_PC;
  endtask

  task automatic cycle(input bit aok, input bit dok_i, input bit rdy, input bit rv,
                       input logic [31:0] rpc);
    bit          dok, exp_req, exp_valid;
    logic [32:0] pr;
    pend_t       p;
    int          idx;
    @(negedge clk);
    resetn = 1'b1;
    dok = dok_i && (pend_q.size() > 0);
    inst_addr_ok = aok; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    inst_data_ok = dok;
    inst_rdata   = dok ? data_of(pend_q[0].addr) : $urandom;
    #1;
    exp_req   = (exp_q.size() < DEPTH) && !rv;
    exp_valid = (exp_q.size() > 0) && exp_q[0].filled;
    check("inst_req", inst_req, exp_req);
    check("bp_predict_en", bp_predict_en, exp_req);
    check("inst_addr", inst_addr, model_pc);
    check("bp_old_PC", bp_old_PC, model_pc);
    check("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      check("if_pc", if_pc, exp_q[0].pc);
      check("if_inst", if_inst, data_of(exp_q[0].pc));
      check("if_pred_jump", if_pred_jump, exp_q[0].pj);
      check("if_pred_target", if_pred_target, exp_q[0].tgt);
    end
    s_req = inst_req; s_addr = inst_addr; s_valid = if_valid; s_pc = if_pc;
    s_inst = if_inst; s_pj = if_pred_jump; s_tgt = if_pred_target;
    s_acc = exp_req && aok;
    s_pop = if_valid && rdy;
    if (rv) begin
      if (dok) void'(pend_q.pop_front());
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      exp_q.delete();
      model_pc = rpc;
    end else begin
      if (exp_valid && rdy) void'(exp_q.pop_front());
      if (dok) begin
        p = pend_q.pop_front();
        if (p.live) begin
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && !exp_q[i].filled) idx = i;
          check("fill_has_entry", idx >= 0, 1);
          if (idx >= 0) exp_q[idx].filled = 1'b1;
        end
      end
      if (s_acc) begin
        pr = pred_fn(model_pc, bp_mode);
        exp_q.push_back('{pc: model_pc, pj: pr[32], tgt: pr[31:0], filled: 1'b0});
        pend_q.push_back('{addr: model_pc, live: 1'b1});
        model_pc = pr[31:0];
      end
    end
  endtask

  typedef struct {
    bit aok, dok, rdy, rv; logic [31:0] rpc;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; bit e_pj; logic [31:0] e_tgt;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int          acc, npop;
    bit          seq_ok;
    logic [31:0] last;

    // Streaming from reset with a taken branch at BFC00008 -> BFC00100.
    vecs[0] = '{1, 0, 1, 0, 0, 1, 32'hBFC0_0000, 0, 32'h0,         0, 32'h0};
    vecs[1] = '{1, 1, 1, 0, 0, 1, 32'hBFC0_0004, 0, 32'h0,         0, 32'h0};
    vecs[2] = '{1, 1, 1, 0, 0, 1, 32'hBFC0_0008, 1, 32'hBFC0_0000, 0, 32'hBFC0_0004};
    vecs[3] = '{1, 1, 1, 0, 0, 1, 32'hBFC0_0100, 1, 32'hBFC0_0004, 0, 32'hBFC0_0008};
    vecs[4] = '{1, 1, 1, 0, 0, 1, 32'hBFC0_0104, 1, 32'hBFC0_0008, 1, 32'hBFC0_0100};
    vecs[5] = '{1, 1, 1, 0, 0, 1, 32'hBFC0_0108, 1, 32'hBFC0_0100, 0, 32'hBFC0_0104};

    bp_mode = 1;
    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].aok, vecs[i].dok, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check($sformatf("vec%0d_req", i), s_req, vecs[i].e_req);
      if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), s_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), s_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_pj", i), s_pj, vecs[i].e_pj);
        check($sformatf("vec%0d_tgt", i), s_tgt, vecs[i].e_tgt);
      end
    end

    // Decode stalled: queue fills to DEPTH, then drains in order.
    bp_mode = 0;
    do_reset();
    acc = 0;
    repeat (8) begin
      cycle(1, 1, 0, 0, 0);
      if (s_acc) acc++;
    end
    check("full_accepts", acc, 4);
    check("full_req_low", s_req, 0);
    check("full_pc_frozen", s_addr, 32'hBFC0_0010);
    npop = 0; seq_ok = 1'b1; last = RST_PC - 32'd4;
    repeat (12) begin
      cycle(1, 1, 1, 0, 0);
      if (s_pop) begin
        if (s_pc != last + 32'd4) seq_ok = 1'b0;
        last = s_pc;
        npop++;
      end
    end
    check("resume_in_order", seq_ok, 1);
    check("resume_rate", npop >= 10, 1);

    // Redirect with two reads outstanding and one returning in the redirect cycle.
    do_reset();
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h8000_0040);
    check("redir_no_req", s_req, 0);
    cycle(0, 1, 1, 0, 0);
    check("redir_new_addr", s_addr, 32'h8000_0040);
    check("redir_stale_hidden", s_valid, 0);
    cycle(1, 0, 1, 0, 0);
    check("redir_wait1", s_valid, 0);
    cycle(0, 1, 1, 0, 0);
    check("redir_wait2", s_valid, 0);
    cycle(0, 0, 1, 0, 0);
    check("redir_first_valid", s_valid, 1);
    check("redir_first_pc", s_pc, 32'h8000_0040);
    check("redir_first_inst", s_inst, data_of(32'h8000_0040));

    // Redirect coinciding with addr_ok and a pop offer.
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 32'h8000_0100);
    check("rp_head_offered", s_valid, 1);
    check("rp_no_req", s_req, 0);
    cycle(0, 1, 1, 0, 0);
    check("rp_empty", s_valid, 0);
    check("rp_req", s_req, 1);
    check("rp_addr", s_addr, 32'h8000_0100);
    cycle(1, 0, 1, 0, 0);
    check("rp_wait", s_valid, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("rp_first_pc", s_pc, 32'h8000_0100);

    // Reset while three entries are buffered.
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("mid_buffered", s_valid, 1);
    do_reset();
    cycle(0, 0, 1, 0, 0);
    check("mid_rst_valid", s_valid, 0);
    check("mid_rst_addr", s_addr, RST_PC);
    check("mid_rst_req", s_req, 1);

    // Randomized traffic against the model.
    bp_mode = 2;
    do_reset();
    repeat (3000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
